score_ram_arbiter: RTL and testbench
====================================

# score_ram_arbiter

Three-port round-robin arbiter that shares the single-port score RAM (16-bit address, 16-bit data, 2-cycle read latency) among the login/auth path (port 0), the score-update path (port 1) and the scoreboard report scanner (port 2). It registers the winning request onto the RAM port, tags in-flight reads, and returns each read word only to the port that issued it. A per-port lock lets one requester hold the RAM across an atomic read-modify-write of a player's score.

## Interface
- ADDR_W, 16, RAM address width
- DATA_W, 16, RAM data width
- RD_LAT, 2, cycles from address on RAM port to valid ram_q
- clk  in  1  clock, all logic rising-edge
- rst  in  1  reset, synchronous, active-low
- req  in  3  per-port request, held until granted
- we  in  3  per-port write enable, qualifies req (1 = write, 0 = read)
- lock  in  3  per-port lock request
- addr0/addr1/addr2  in  ADDR_W  per-port address
- wdata0/wdata1/wdata2  in  DATA_W  per-port write data
- gnt  out  3  one-hot grant, combinational, same cycle as accepted req
- rvalid  out  3  one-hot read-data-valid
- rdata  out  DATA_W  read data, shared by all ports, qualified by rvalid
- ram_wren  out  1  RAM write enable (registered)
- ram_address  out  ADDR_W  RAM address (registered)
- ram_data  out  DATA_W  RAM write data (registered)
- ram_q  in  DATA_W  RAM read data
- owner  out  2  current lock owner, 2'd3 = none

## Operation
- Priority pointer ptr (0..2); search order ptr, ptr+1, ptr+2 mod 3. Grant at most one port per cycle: the first port with req=1 in that order.
- After granting port i, ptr <= (i+1) mod 3. No grant: ptr unchanged.
- Lock: if gnt[i] and lock[i] in the same cycle, owner <= i. While owner = k and lock[k] = 1, only port k may be granted; other requests wait even if port k is idle. When lock[owner] = 0, owner <= 3 at the next edge and arbitration resumes from ptr in that same cycle. lock without a grant has no effect.
- On grant: ram_address <= addr_i, ram_data <= wdata_i, ram_wren <= we[i]. With no grant: ram_wren <= 0; ram_address and ram_data keep their values.
- Read tagging: shift register of RD_LAT+1 stages, each {valid, port id}. Stage 0 loads {gnt & ~we, i}. The output stage drives rvalid[id] = valid, with rdata = ram_q in the same cycle.
- Writes generate no rvalid.
- The RAM port is fully pipelined. A new grant is allowed every cycle, and any mix of reads and writes is accepted back to back.

## Timing
- Grant cycle T: gnt[i] = 1 combinationally. The requester may change req, addr and wdata from T+1.
- T+1: ram_address, ram_wren and ram_data show the request.
- Read: ram_q is valid at T+1+RD_LAT = T+3. rvalid[i] = 1 and rdata are valid at T+3 for one cycle.
- Write: the RAM captures it at the T+1 edge. A read of the same address granted at T+1 returns the new value.
- Reset (rst = 0 at an edge): gnt = 0, rvalid = 0, rdata = 0, ram_wren = 0, ram_address = 0, ram_data = 0, ptr = 0, owner = 3, all tag stages invalid.
- During reset, gnt is forced to 0 combinationally.
- Reset mid-operation discards in-flight reads: no rvalid for them after rst returns high.
- Simultaneous lock release and another port's req: release takes effect at the next edge, so the other port is granted one cycle later.
- The lock owner's port may itself issue reads and writes every cycle while it holds the lock.

## Test plan
- Single read: after reset, port 1 reads addr 0x0010, RAM holds 0x00AB there. Required: gnt = 3'b010 at T, ram_address = 0x0010 with ram_wren = 0 at T+1, rvalid = 3'b010 with rdata = 0x00AB at T+3, rvalid = 0 at T+4.
- Round-robin: all three ports hold req (reads) from reset. Required: grants 0, 1, 2, 0, 1, 2 on consecutive cycles; each rvalid returns to the matching port 3 cycles after its grant.
- Write then read: port 0 writes 0x1234 to 0x0005 at T, then reads 0x0005 at T+1. Required: ram_wren = 1 at T+1 only; rvalid[0] at T+4 with rdata = 0x1234; no rvalid at T+3.
- Locked RMW: port 1 reads with lock = 1 while ports 0 and 2 request. Port 1 keeps lock for 4 cycles, then writes. Required: only gnt[1] is seen while locked and owner = 1; after lock drops, owner = 3 and the next grants follow ptr.
- Reset mid-flight: port 2 read granted at T, rst = 0 at T+1 for one cycle. Required: no rvalid at T+3, ram_wren = 0 and owner = 3 after reset, and the first grant after reset goes to port 0 when all ports request.

Source files
------------

// File: rtl/score_ram_arbiter.sv
// score_ram_arbiter: round-robin, lockable three-port front end for the
// single-port score RAM, with read tags steering data back to the issuer.
module score_ram_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        req,
  input  logic [2:0]        we,
  input  logic [2:0]        lock,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [DATA_W-1:0] wdata2,
  output logic [2:0]        gnt,
  output logic [2:0]        rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_wren,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  input  logic [DATA_W-1:0] ram_q,
  output logic [1:0]        owner
);

  localparam logic [1:0] NONE = 2'd3;

  typedef struct packed {
    logic       v;
    logic [1:0] id;
  } tag_t;

  logic [1:0]        r_ptr;
  logic [1:0]        r_owner;
  logic [1:0]        w_owner_nxt;
  logic [2:0]        w_elig;
  logic [2:0]        w_hit;
  logic [1:0]        w_c0;
  logic [1:0]        w_c1;
  logic [1:0]        w_c2;
  logic [1:0]        w_gid;
  logic              w_any;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  tag_t              w_tag_in;
  tag_t [RD_LAT:0]   r_tag;

  function automatic logic [1:0] f_next(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // search order: ptr, ptr+1, ptr+2 (mod 3)
  assign w_c0 = r_ptr;
  assign w_c1 = f_next(r_ptr);
  assign w_c2 = f_next(w_c1);

  assign w_hit[0] = req[w_c0] & w_elig[w_c0];
  assign w_hit[1] = req[w_c1] & w_elig[w_c1];
  assign w_hit[2] = req[w_c2] & w_elig[w_c2];

  always_comb begin
    w_any = 1'b1;
    w_gid = w_c0;
    priority case (1'b1)
      w_hit[0]: w_gid = w_c0;
      w_hit[1]: w_gid = w_c1;
      w_hit[2]: w_gid = w_c2;
      default:  w_any = 1'b0;
    endcase
  end

  assign gnt = (rst && w_any) ? (3'b001 << w_gid) : 3'b000;

  always_comb begin
    w_addr  = addr0;
    w_wdata = wdata0;
    w_we    = we[0];
    unique case (w_gid)
      2'd1: begin
        w_addr  = addr1;
        w_wdata = wdata1;
        w_we    = we[1];
      end
      2'd2: begin
        w_addr  = addr2;
        w_wdata = wdata2;
        w_we    = we[2];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ram_wren    <= 1'b0;
      ram_address <= '0;
      ram_data    <= '0;
    end else if (w_any) begin
      ram_wren    <= w_we;
      ram_address <= w_addr;
      ram_data    <= w_wdata;
    end else begin
      ram_wren    <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ptr <= 2'd0;
    end else if (w_any) begin
      r_ptr <= f_next(w_gid);
    end
  end

  // lock owner: state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_owner <= NONE;
    end else begin
      r_owner <= w_owner_nxt;
    end
  end

  // lock owner: next state; release is seen one edge late
  always_comb begin
    w_owner_nxt = r_owner;
    if (r_owner != NONE) begin
      if (!lock[r_owner]) begin
        w_owner_nxt = NONE;
      end
    end else if (w_any && lock[w_gid]) begin
      w_owner_nxt = w_gid;
    end
  end

  // lock owner: outputs
  always_comb begin
    owner  = r_owner;
    w_elig = 3'b111;
    if (r_owner != NONE) begin
      w_elig = 3'b001 << r_owner;
    end
  end

  assign w_tag_in.v  = w_any & ~w_we;
  assign w_tag_in.id = w_gid;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tag <= '0;
    end else begin
      r_tag <= {r_tag[RD_LAT-1:0], w_tag_in};
    end
  end

  assign rvalid = r_tag[RD_LAT].v ? (3'b001 << r_tag[RD_LAT].id) : 3'b000;
  assign rdata  = r_tag[RD_LAT].v ? ram_q : '0;

  a_gnt_onehot: assert property (@(posedge clk) $onehot0(gnt));
  a_gnt_req:    assert property (@(posedge clk) (gnt & ~req) == 3'b000);
  a_rv_onehot:  assert property (@(posedge clk) $onehot0(rvalid));

endmodule

// File: tb/tb_score_ram_arbiter.sv
// tb_score_ram_arbiter: directed stimulus with a read-data scoreboard
// and a 2-cycle RAM model behind the arbiter.
module tb_score_ram_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  req;
  logic [2:0]  we;
  logic [2:0]  lock;
  logic [15:0] addr0, addr1, addr2;
  logic [15:0] wdata0, wdata1, wdata2;
  logic [2:0]  gnt;
  logic [2:0]  rvalid;
  logic [15:0] rdata;
  logic        ram_wren;
  logic [15:0] ram_address;
  logic [15:0] ram_data;
  logic [15:0] ram_q;
  logic [1:0]  owner;

  score_ram_arbiter #(
    .ADDR_W(16),
    .DATA_W(16),
    .RD_LAT(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .we(we),
    .lock(lock),
    .addr0(addr0),
    .addr1(addr1),
    .addr2(addr2),
    .wdata0(wdata0),
    .wdata1(wdata1),
    .wdata2(wdata2),
    .gnt(gnt),
    .rvalid(rvalid),
    .rdata(rdata),
    .ram_wren(ram_wren),
    .ram_address(ram_address),
    .ram_data(ram_data),
    .ram_q(ram_q),
    .owner(owner)
  );

  typedef struct {
    int          cyc;
    int          port;
    logic [15:0] d;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          mon_en = 0;
  logic [15:0] mem [0:255];
  logic [15:0] s1;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: address registered at T+1, data out two edges later
  always @(posedge clk) begin
    if (ram_wren === 1'b1) mem[ram_address[7:0]] <= ram_data;
    s1    <= mem[ram_address[7:0]];
    ram_q <= s1;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int port, input logic [15:0] d);
    exp_t e;
    e.cyc  = cyc + 3;
    e.port = port;
    e.d    = d;
    q.push_back(e);
  endtask

  task automatic cyc_do(input logic [2:0] rq, input logic [2:0] wq,
                        input logic [2:0] lk, input logic [2:0] eg,
                        input string nm);
    @(posedge clk);
    #1;
    rst  = 1;
    req  = rq;
    we   = wq;
    lock = lk;
    @(negedge clk);
    chk(nm, {29'd0, gnt}, {29'd0, eg});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rst  = 1;
      req  = 0;
      we   = 0;
      lock = 0;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst  = 0;
    req  = 0;
    we   = 0;
    lock = 0;
    @(negedge clk);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (mon_en && rvalid != 3'b000) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rvalid_unexpected: got rvalid %b rdata %h at cycle %0d, expected none",
                 rvalid, rdata, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rvalid_port", {29'd0, rvalid}, 32'd1 << e.port);
        chk("rdata", {16'd0, rdata}, {16'd0, e.d});
        chk("rvalid_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h10] = 16'h00AB;
    mem[8'h20] = 16'hA020;
    mem[8'h21] = 16'hA021;
    mem[8'h22] = 16'hA022;
    mem[8'h05] = 16'hDEAD;
    mem[8'h30] = 16'h0100;
    mem[8'h40] = 16'h0400;
    mem[8'h50] = 16'h0500;
    mem[8'h60] = 16'h0600;
    rst = 0; req = 3'b111; we = 0; lock = 0;
    addr0 = 16'h00FF; addr1 = 16'h00FF; addr2 = 16'h00FF;
    wdata0 = 0; wdata1 = 0; wdata2 = 0;

    // reset state, gnt forced low while requests are held
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", {29'd0, gnt}, 32'd0);
    chk("rst_owner", {30'd0, owner}, 32'd3);
    chk("rst_wren", {31'd0, ram_wren}, 32'd0);
    chk("rst_addr", {16'd0, ram_address}, 32'd0);
    chk("rst_data", {16'd0, ram_data}, 32'd0);
    chk("rst_rvalid", {29'd0, rvalid}, 32'd0);
    chk("rst_rdata", {16'd0, rdata}, 32'd0);
    mon_en = 1;
    req = 0;
    addr1 = 16'h0010;

    // single read
    cyc_do(3'b010, 3'b000, 3'b000, 3'b010, "t1_gnt");
    push(1, 16'h00AB);
    cyc_do(3'b000, 3'b000, 3'b000, 3'b000, "t1_idle_gnt");
    chk("t1_ram_addr", {16'd0, ram_address}, 32'h10);
    chk("t1_ram_wren", {31'd0, ram_wren}, 32'd0);
    idle(5);

    // round robin from reset
    addr0 = 16'h0020; addr1 = 16'h0021; addr2 = 16'h0022;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      cyc_do(3'b111, 3'b000, 3'b000, 3'b001 << (k % 3), "t2_rr_gnt");
      push(k % 3, 16'hA020 + 16'(k % 3));
    end
    idle(5);

    // write then read same address
    addr0 = 16'h0005; wdata0 = 16'h1234;
    cyc_do(3'b001, 3'b001, 3'b000, 3'b001, "t3_wr_gnt");
    cyc_do(3'b001, 3'b000, 3'b000, 3'b001, "t3_rd_gnt");
    push(0, 16'h1234);
    chk("t3_wren_t1", {31'd0, ram_wren}, 32'd1);
    chk("t3_addr_t1", {16'd0, ram_address}, 32'h5);
    chk("t3_data_t1", {16'd0, ram_data}, 32'h1234);
    cyc_do(3'b000, 3'b000, 3'b000, 3'b000, "t3_idle_gnt");
    chk("t3_wren_t2", {31'd0, ram_wren}, 32'd0);
    idle(5);

    // locked read-modify-write by port 1
    addr0 = 16'h0040; addr1 = 16'h0030; addr2 = 16'h0050;
    wdata1 = 16'h0101;
    cyc_do(3'b111, 3'b000, 3'b010, 3'b010, "t4_lock_gnt");
    push(1, 16'h0100);
    for (int k = 0; k < 3; k++) begin
      cyc_do(3'b101, 3'b000, 3'b010, 3'b000, "t4_held_gnt");
      chk("t4_owner_held", {30'd0, owner}, 32'd1);
    end
    cyc_do(3'b111, 3'b010, 3'b000, 3'b010, "t4_release_gnt");
    chk("t4_owner_rel", {30'd0, owner}, 32'd1);
    cyc_do(3'b101, 3'b000, 3'b000, 3'b100, "t4_after_gnt");
    push(2, 16'h0500);
    chk("t4_owner_none", {30'd0, owner}, 32'd3);
    chk("t4_wren", {31'd0, ram_wren}, 32'd1);
    chk("t4_wr_addr", {16'd0, ram_address}, 32'h30);
    chk("t4_wr_data", {16'd0, ram_data}, 32'h0101);
    cyc_do(3'b001, 3'b000, 3'b000, 3'b001, "t4_next_gnt");
    push(0, 16'h0400);
    idle(5);

    // reset mid-flight discards the in-flight read
    addr2 = 16'h0060;
    cyc_do(3'b100, 3'b000, 3'b100, 3'b100, "t5_pre_gnt");
    do_reset();
    cyc_do(3'b111, 3'b000, 3'b000, 3'b001, "t5_post_gnt");
    push(0, 16'h0400);
    chk("t5_wren", {31'd0, ram_wren}, 32'd0);
    chk("t5_addr", {16'd0, ram_address}, 32'd0);
    chk("t5_owner", {30'd0, owner}, 32'd3);
    idle(6);

    chk("pending_reads", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
